// File: rtl/regfile_port_ctrl.sv
// Port-1 owner for the 16x16 register file: queued writeback drains plus coherent reads.
// Optional macro RF_FWD_EN: forward queued write data to reads instead of stalling them.
module regfile_port_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wq_valid,
  output logic        wq_ready,
  input  logic [3:0]  wq_addr,
  input  logic [15:0] wq_data,
  output logic        wq_empty,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [3:0]  rd_addr,
  output logic        rd_resp_valid,
  output logic [15:0] rd_data,
  output logic [3:0]  rf_rwa1,
  output logic        rf_we,
  output logic [15:0] rf_wd,
  input  logic [15:0] rf_rd1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_READ  = 2'd1,
    GRANT_DRAIN = 2'd2
  } grant_t;

  logic [3:0]    addr_mem_r [DEPTH];
  logic [15:0]   data_mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          rd_resp_valid_r;
  logic [15:0]   rd_data_r;

  logic          full_s;
  logic          empty_s;
  logic          match_s;
  logic          read_ok_s;
  logic          push_s;
  logic          pop_s;
  logic [15:0]   resp_data_s;
  grant_t        grant_s;
`ifdef RF_FWD_EN
  logic [15:0]   fwd_data_s;
`endif

  assign full_s   = (count_r == CW'(DEPTH));
  assign empty_s  = (count_r == {CW{1'b0}});
  assign wq_ready = ~full_s;
  assign wq_empty = empty_s;
  assign push_s   = wq_valid & ~full_s;
  assign pop_s    = (grant_s == GRANT_DRAIN);

  // Hazard scan over live entries, oldest to newest, so the newest match wins
  always_comb begin
    match_s = 1'b0;
`ifdef RF_FWD_EN
    fwd_data_s = 16'h0000;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      match_s = match_s |
                ((CW'(i) < count_r) && (addr_mem_r[head_r + PW'(i)] == rd_addr));
`ifdef RF_FWD_EN
      fwd_data_s = ((CW'(i) < count_r) && (addr_mem_r[head_r + PW'(i)] == rd_addr)) ?
                   data_mem_r[head_r + PW'(i)] : fwd_data_s;
`endif
    end
  end

`ifdef RF_FWD_EN
  assign read_ok_s   = 1'b1;
  assign resp_data_s = match_s ? fwd_data_s : rf_rd1;
`else
  assign read_ok_s   = ~match_s;
  assign resp_data_s = rf_rd1;
`endif

  // Port-1 arbitration: a full queue always drains so reads cannot starve writes
  always_comb begin
    grant_s = GRANT_IDLE;
    if (!rst_n) begin
      grant_s = GRANT_IDLE;
    end else if (full_s) begin
      grant_s = GRANT_DRAIN;
    end else if (rd_valid && read_ok_s) begin
      grant_s = GRANT_READ;
    end else if (!empty_s) begin
      grant_s = GRANT_DRAIN;
    end else begin
      grant_s = GRANT_IDLE;
    end
  end

  // Register-file port drive for the granted operation
  always_comb begin
    rd_ready = 1'b0;
    rf_we    = 1'b0;
    rf_rwa1  = 4'h0;
    rf_wd    = 16'h0000;
    case (grant_s)
      GRANT_READ: begin
        rd_ready = 1'b1;
        rf_rwa1  = rd_addr;
      end
      GRANT_DRAIN: begin
        rf_we   = 1'b1;
        rf_rwa1 = addr_mem_r[head_r];
        rf_wd   = data_mem_r[head_r];
      end
      default: begin
        rd_ready = 1'b0;
        rf_we    = 1'b0;
      end
    endcase
  end

  // Queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= 4'h0;
        data_mem_r[i] <= 16'h0000;
      end
    end else if (push_s) begin
      addr_mem_r[tail_r] <= wq_addr;
      data_mem_r[tail_r] <= wq_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid_r <= 1'b0;
      rd_data_r       <= 16'h0000;
    end else if (grant_s == GRANT_READ) begin
      rd_resp_valid_r <= 1'b1;
      rd_data_r       <= resp_data_s;
    end else begin
      rd_resp_valid_r <= 1'b0;
    end
  end

  assign rd_resp_valid = rd_resp_valid_r;
  assign rd_data       = rd_data_r;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: queue-level reference model, directed and random stimulus.
module tb_regfile_port_ctrl;

  localparam int DEPTH = 4;
`ifdef RF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wq_valid = 1'b0;
  logic        wq_ready;
  logic [3:0]  wq_addr = 4'h0;
  logic [15:0] wq_data = 16'h0000;
  logic        wq_empty;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [3:0]  rd_addr = 4'h0;
  logic        rd_resp_valid;
  logic [15:0] rd_data;
  logic [3:0]  rf_rwa1;
  logic        rf_we;
  logic [15:0] rf_wd;
  logic [15:0] rf_rd1;

  always #5 clk = ~clk;

  regfile_port_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wq_valid(wq_valid), .wq_ready(wq_ready), .wq_addr(wq_addr), .wq_data(wq_data),
    .wq_empty(wq_empty),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_data(rd_data),
    .rf_rwa1(rf_rwa1), .rf_we(rf_we), .rf_wd(rf_wd), .rf_rd1(rf_rd1)
  );

  // Register file the DUT drives; not reset, r2 preloaded with 0xA5A5
  logic [15:0] regs [16];
  logic        env_ready = 1'b0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 16; i++) regs[i] <= (i == 2) ? 16'hA5A5 : 16'h0000;
    end else if (rf_we) begin
      regs[rf_rwa1] <= rf_wd;
    end
  end
  assign rf_rd1 = regs[rf_rwa1];

  typedef struct packed {logic [3:0] a; logic [15:0] d;} ent_t;
  ent_t        q[$];
  logic [15:0] mregs [16];
  logic        exp_rv = 1'b0;
  logic [15:0] exp_rd = 16'h0000;
  logic        g_read, g_drain;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, advance the model
  task automatic step(input logic v, input logic [3:0] a, input logic [15:0] d,
                      input logic rv, input logic [3:0] ra);
    bit m, full, rd_g, dr_g;
    logic [15:0] fd;
    logic [3:0] ea;
    int n;
    @(negedge clk);
    wq_valid = v; wq_addr = a; wq_data = d; rd_valid = rv; rd_addr = ra;
    #1;
    n = q.size();
    full = (n == DEPTH);
    m = 1'b0; fd = 16'h0000;
    foreach (q[i]) if (q[i].a == ra) begin m = 1'b1; fd = q[i].d; end
    rd_g = 1'b0; dr_g = 1'b0;
    if (full) dr_g = 1'b1;
    else if (rv && (FWD || !m)) rd_g = 1'b1;
    else if (n > 0) dr_g = 1'b1;
    ea = rd_g ? ra : (dr_g ? q[0].a : 4'h0);
    chk("wq_ready", wq_ready, !full);
    chk("wq_empty", wq_empty, n == 0);
    chk("rd_ready", rd_ready, rd_g);
    chk("rf_we", rf_we, dr_g);
    chk("rf_rwa1", rf_rwa1, ea);
    if (dr_g) chk("rf_wd", rf_wd, q[0].d);
    chk("rd_resp_valid", rd_resp_valid, exp_rv);
    chk("rd_data", rd_data, exp_rd);
    if (rd_g) begin
      exp_rv = 1'b1;
      exp_rd = (FWD && m) ? fd : mregs[ra];
    end else begin
      exp_rv = 1'b0;
    end
    if (dr_g) begin
      mregs[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (v && !full) q.push_back({a, d});
    g_read = rd_g; g_drain = dr_g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wq_valid = 1'b1; wq_addr = 4'hF; wq_data = 16'hDEAD; rd_valid = 1'b1; rd_addr = 4'h0;
    #1;
    chk("rst_wq_ready", wq_ready, 1);
    chk("rst_wq_empty", wq_empty, 1);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_resp_valid", rd_resp_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rwa1", rf_rwa1, 0);
    chk("rst_rf_wd", rf_wd, 0);
    q.delete();
    exp_rv = 1'b0;
    exp_rd = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    wq_valid = 1'b0; rd_valid = 1'b0;
  endtask

  initial begin
    int lows;
    for (int i = 0; i < 16; i++) mregs[i] = (i == 2) ? 16'hA5A5 : 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    env_ready = 1'b1;
    do_reset();

    // Two writes, no reads
    step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0);
    chk("wr_t0_no_we", rf_we, 0);
    step(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0);
    chk("wr_t1_we", rf_we, 1);
    chk("wr_t1_addr", rf_rwa1, 4'd3);
    chk("wr_t1_data", rf_wd, 16'h1234);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("wr_t2_addr", rf_rwa1, 4'd5);
    chk("wr_t2_data", rf_wd, 16'hBEEF);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("wr_empty_after", wq_empty, 1);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("rd_r3_data", rd_data, 16'h1234);

    // Unqueued read of r2
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd2);
    chk("rd_r2_no_we", rf_we, 0);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("rd_r2_valid", rd_resp_valid, 1);
    chk("rd_r2_data", rd_data, 16'hA5A5);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("rd_r2_pulse", rd_resp_valid, 0);

    // Fill while reading, then a full queue forces one drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(8 + i), 16'(16'h0800 + i), 1'b1, 4'd0);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0);
    chk("full_wq_ready", wq_ready, 0);
    chk("full_rd_ready", rd_ready, 0);
    chk("full_drain_addr", rf_rwa1, 4'd8);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0);
    chk("full_then_read", rd_ready, 1);
    repeat (DEPTH) step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);

    // Same-register hazard
    step(1'b1, 4'd7, 16'h0001, 1'b1, 4'd0);
    step(1'b1, 4'd7, 16'h0002, 1'b1, 4'd0);
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7);
      if (g_read) break;
      lows++;
    end
    chk("hz_blocked_cycles", lows, FWD ? 0 : 2);
    chk("hz_accept_no_we", rf_we, 0);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("hz_resp_valid", rd_resp_valid, 1);
    chk("hz_rd_data", rd_data, 16'h0002);
    repeat (DEPTH) step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);

    // Steady enqueue+drain at occupancy 2, wrapping the pointers
    step(1'b1, 4'd12, 16'h0100, 1'b1, 4'd0);
    step(1'b1, 4'd13, 16'h0101, 1'b1, 4'd0);
    for (int i = 2; i < 10; i++) begin
      step(1'b1, 4'(12 + (i % 4)), 16'(16'h0100 + i), 1'b0, 4'd0);
      chk("steady_wd", rf_wd, 16'(16'h0100 + i - 2));
      chk("steady_not_empty", wq_empty, 0);
    end
    repeat (3) step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);

    // Reset in the middle of draining
    step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd0);
    step(1'b1, 4'd4, 16'h4444, 1'b1, 4'd0);
    step(1'b1, 4'd6, 16'h6666, 1'b1, 4'd0);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("mid_drain_we", rf_we, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
      chk("post_rst_no_we", rf_we, 0);
    end
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd4);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("post_rst_r4", rd_data, 16'h0000);

    // Random traffic over a narrow address range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
